tile_writeback: RTL and testbench
=================================

Name: tile_writeback

Overview:
- Downstream of the pixel shader: copies one finished 8x8 colour tile from the shader's double-buffered colour tiles (cBufferTile0/cBufferTile1) into the external 16-bit SRAM framebuffer.
- Started by the tile controller once the shader reports doneRasterizing.
- Writes to the tile selected at start while the shader fills the other one.
- Clips pixels that fall outside the screen and reports completion with a one-cycle pulse.

Parameters:
- tileDim, 8, tile edge length in pixels (tile is tileDim x tileDim).
- SCREEN_W, 640, framebuffer width in pixels; also the row pitch in words.
- SCREEN_H, 480, framebuffer height in pixels.

Ports:
- BOARD_CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- cBufferTile0  input  16 x [tileDim][tileDim]  colour tile 0, indexed [x][y].
- cBufferTile1  input  16 x [tileDim][tileDim]  colour tile 1, indexed [x][y].
- writeTileID  input  1  selects the tile to copy; sampled on start.
- tileOffsetX, tileOffsetY  input  10 each  screen position of tile pixel (0,0); sampled on start.
- startWriteback  input  1  start request, level or pulse.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- doneWriteback  output  1  one-cycle pulse when the tile is fully written; the tile buffer is free from this cycle on.
- pixelsWritten  output  7  count of SRAM writes issued for the current or last tile.
- SRAM_ADDR  output  20  word address.
- SRAM_DQ  output  16  write data.
- SRAM_DQ_EN  output  1  tristate enable for the top-level DQ driver.
- SRAM_WE_N  output  1  active-low write strobe.
- SRAM_CE_N  output  1  active-low chip enable.

Behaviour:
- Reset values (asynchronous, active-high):
  - State machine in IDLE.
  - busy=0, doneWriteback=0, pixelsWritten=0.
  - SRAM_ADDR=0, SRAM_DQ=0, SRAM_DQ_EN=0, SRAM_WE_N=1, SRAM_CE_N=1.
  - Internal x=y=0; latched tile ID and offsets = 0.
- Reset mid-operation: abandons the tile immediately and does not pulse doneWriteback. SRAM_WE_N is deasserted asynchronously.
- IDLE:
  - If startWriteback=1, latch writeTileID, tileOffsetX, tileOffsetY.
  - Set x=y=0, pixelsWritten=0, then go to SETUP.
  - Otherwise stay in IDLE.
  - startWriteback is ignored in every other state; no queuing.
- Screen coordinates: sx = tileOffsetX + x and sy = tileOffsetY + y, both computed at 11 bits with no wrap.
  - A pixel is in bounds iff sx < SCREEN_W and sy < SCREEN_H.
- SETUP, pixel in bounds:
  - Register SRAM_ADDR = sy*SCREEN_W + sx, truncated to 20 bits.
  - Register SRAM_DQ = selected tile[x][y].
  - Set SRAM_DQ_EN=1, SRAM_CE_N=0, SRAM_WE_N=1, then go to STROBE.
- SETUP, pixel out of bounds: no SRAM cycle is issued. Advance the pixel and stay in SETUP, or go to DONE if this was the last pixel.
- STROBE:
  - SRAM_WE_N=0 for exactly one cycle; address and data held stable.
  - pixelsWritten increments.
  - Advance the pixel; next state SETUP, or DONE if this was the last pixel.
- Pixel advance order: x is the inner loop (0..tileDim-1), y the outer loop. The last pixel is (tileDim-1, tileDim-1).
- DONE:
  - doneWriteback=1 and busy=1 for this one cycle.
  - SRAM_WE_N=1, SRAM_CE_N=1, SRAM_DQ_EN=0.
  - Next state IDLE.
- Timing:
  - Each in-bounds pixel costs 2 cycles; each clipped pixel costs 1 cycle.
  - A fully in-bounds 8x8 tile takes 128 cycles from the first SETUP, then DONE on cycle 129 after the start is accepted.
- Tile buffer contents must stay stable while busy. The selected buffer is read combinationally in SETUP only.
- SRAM_WE_N is never low in two consecutive cycles.
- Address and data never change in the cycle SRAM_WE_N is low.

Test Plan:
- Full tile: reset, offsets (0,0), tile0[x][y]=x+8y, start one cycle.
  - Expect 64 strobes at addresses y*640+x with data x+8y, in x-inner order.
  - Expect doneWriteback exactly 129 cycles after start and pixelsWritten=64.
- Tile select and offset: tile1 filled with 16'hBEEF, tile0 with 0, writeTileID=1, offsets (16,8).
  - Expect first address 8*640+16=5136, last address 15*640+23=9623, all data BEEF.
- Right/bottom clip: offsets (636,476).
  - Expect only sx 636..639 and sy 476..479 written, i.e. 16 strobes and pixelsWritten=16.
  - Expect done after 1 + 16*2 + 48*1 = 81 cycles.
- Fully off-screen: offsets (700,0).
  - Expect no strobe, SRAM_WE_N held 1, doneWriteback after 65 cycles, pixelsWritten=0.
- Start while busy: pulse startWriteback again at cycle 30 with writeTileID changed.
  - Expect no restart, data still from the original tile, and a single doneWriteback.
- Reset mid-tile: assert RESET at cycle 40.
  - Expect SRAM_WE_N=1, busy=0, pixelsWritten=0 immediately and no doneWriteback.
  - After release, a new start completes normally.

Source files
------------

// File: rtl/tile_writeback.sv
// Copies one 8x8 colour tile from the shader's double-buffered tiles into the
// 16-bit SRAM framebuffer, clipping pixels that fall off-screen.
module tile_writeback #(
    parameter int tileDim  = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                                   BOARD_CLK,
    input  logic                                   RESET,
    input  logic [tileDim-1:0][tileDim-1:0][15:0]  cBufferTile0,
    input  logic [tileDim-1:0][tileDim-1:0][15:0]  cBufferTile1,
    input  logic                                   writeTileID,
    input  logic [9:0]                             tileOffsetX,
    input  logic [9:0]                             tileOffsetY,
    input  logic                                   startWriteback,
    output logic                                   busy,
    output logic                                   doneWriteback,
    output logic [6:0]                             pixelsWritten,
    output logic [19:0]                            SRAM_ADDR,
    output logic [15:0]                            SRAM_DQ,
    output logic                                   SRAM_DQ_EN,
    output logic                                   SRAM_WE_N,
    output logic                                   SRAM_CE_N
);

    localparam int             CW   = (tileDim > 1) ? $clog2(tileDim) : 1;
    localparam logic [CW-1:0]  LAST = CW'(tileDim - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  x_q, x_d, y_q, y_d;
    logic           sel_q, sel_d;
    logic [9:0]     offx_q, offx_d, offy_q, offy_d;
    logic [6:0]     pix_q, pix_d;
    logic [19:0]    addr_q, addr_d;
    logic [15:0]    dq_q, dq_d;
    logic           dq_en_q, dq_en_d, we_n_q, we_n_d, ce_n_q, ce_n_d;

    logic [10:0]    sx, sy;
    logic           in_bounds, last_px;
    logic [15:0]    pixel;
    logic [CW-1:0]  x_adv, y_adv;

    assign sx        = 11'(offx_q) + 11'(x_q);
    assign sy        = 11'(offy_q) + 11'(y_q);
    assign in_bounds = (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));
    assign last_px   = (x_q == LAST) && (y_q == LAST);
    assign pixel     = sel_q ? cBufferTile1[x_q][y_q] : cBufferTile0[x_q][y_q];
    // x is the inner loop; y only steps when x wraps
    assign x_adv     = (x_q == LAST) ? '0 : x_q + 1'b1;
    assign y_adv     = (x_q == LAST) ? y_q + 1'b1 : y_q;

    // NOTE: every variable gets its default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        offx_d  = offx_q;
        offy_d  = offy_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        dq_en_d = dq_en_q;
        ce_n_d  = ce_n_q;
        we_n_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (startWriteback) begin
                    sel_d   = writeTileID;
                    offx_d  = tileOffsetX;
                    offy_d  = tileOffsetY;
                    x_d     = '0;
                    y_d     = '0;
                    pix_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (in_bounds) begin
                    addr_d  = 20'(sy) * 20'(SCREEN_W) + 20'(sx);
                    dq_d    = pixel;
                    dq_en_d = 1'b1;
                    ce_n_d  = 1'b0;
                    we_n_d  = 1'b0;
                    state_d = S_STROBE;
                end else begin
                    x_d     = x_adv;
                    y_d     = y_adv;
                    dq_en_d = 1'b0;
                    ce_n_d  = 1'b1;
                    state_d = last_px ? S_DONE : S_SETUP;
                end
            end
            S_STROBE: begin
                pix_d = pix_q + 7'd1;
                x_d   = x_adv;
                y_d   = y_adv;
                if (last_px) begin
                    dq_en_d = 1'b0;
                    ce_n_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                dq_en_d = 1'b0;
                ce_n_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge BOARD_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= 1'b0;
            offx_q  <= '0;
            offy_q  <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            dq_en_q <= 1'b0;
            we_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            offx_q  <= offx_d;
            offy_q  <= offy_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            dq_en_q <= dq_en_d;
            we_n_q  <= we_n_d;
            ce_n_q  <= ce_n_d;
        end
    end

    // Strobe comes from its own flop so it is low exactly during the STROBE cycle, glitch-free
    assign busy          = (state_q != S_IDLE);
    assign doneWriteback = (state_q == S_DONE);
    assign pixelsWritten = pix_q;
    assign SRAM_ADDR     = addr_q;
    assign SRAM_DQ       = dq_q;
    assign SRAM_DQ_EN    = dq_en_q;
    assign SRAM_WE_N     = we_n_q;
    assign SRAM_CE_N     = ce_n_q;

endmodule

// File: tb/tb_tile_writeback.sv
// Scoreboard bench for tile_writeback: expected SRAM writes are queued when a
// tile is started and a negedge monitor pops and compares each strobe.
module tb_tile_writeback;

    logic                        BOARD_CLK = 1'b0;
    logic                        RESET = 1'b1;
    logic [7:0][7:0][15:0]       tile0, tile1;
    logic                        writeTileID = 1'b0;
    logic [9:0]                  tileOffsetX = '0, tileOffsetY = '0;
    logic                        startWriteback = 1'b0;
    logic                        busy, doneWriteback, SRAM_DQ_EN, SRAM_WE_N, SRAM_CE_N;
    logic [6:0]                  pixelsWritten;
    logic [19:0]                 SRAM_ADDR;
    logic [15:0]                 SRAM_DQ;

    tile_writeback dut (
        .BOARD_CLK      (BOARD_CLK),
        .RESET          (RESET),
        .cBufferTile0   (tile0),
        .cBufferTile1   (tile1),
        .writeTileID    (writeTileID),
        .tileOffsetX    (tileOffsetX),
        .tileOffsetY    (tileOffsetY),
        .startWriteback (startWriteback),
        .busy           (busy),
        .doneWriteback  (doneWriteback),
        .pixelsWritten  (pixelsWritten),
        .SRAM_ADDR      (SRAM_ADDR),
        .SRAM_DQ        (SRAM_DQ),
        .SRAM_DQ_EN     (SRAM_DQ_EN),
        .SRAM_WE_N      (SRAM_WE_N),
        .SRAM_CE_N      (SRAM_CE_N)
    );

    always #5 BOARD_CLK = ~BOARD_CLK;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [19:0] first_addr, last_addr;
    logic        prev_we_low = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every strobe against the scoreboard head
    always @(negedge BOARD_CLK) begin
        if (doneWriteback) done_cnt++;
        if (SRAM_WE_N === 1'b0) begin
            check("we_single_cycle", {31'd0, prev_we_low}, 32'd0);
            if (wr_cnt == 0) first_addr = SRAM_ADDR;
            last_addr = SRAM_ADDR;
            wr_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {12'd0, SRAM_ADDR}, {12'd0, e.addr});
                check("wr_data", {16'd0, SRAM_DQ}, {16'd0, e.data});
            end
        end
        prev_we_low = (SRAM_WE_N === 1'b0);
    end

    // Queue the writes for a tile at (ox,oy) whose visible region is [0,cols) x [0,rows)
    task automatic push_tile(input logic id, input int ox, input int oy, input int cols, input int rows);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                wr_t e;
                e.addr = 20'((oy + y) * 640 + ox + x);
                e.data = id ? tile1[x][y] : tile0[x][y];
                sb.push_back(e);
            end
        end
    endtask

    task automatic run_tile(input string tag, input logic id, input logic [9:0] ox, input logic [9:0] oy,
                            input int exp_done, input int exp_pix, input int exp_wr,
                            input int restart_at, input int reset_at);
        int n;
        int d0;
        d0 = done_cnt;
        wr_cnt = 0;
        @(negedge BOARD_CLK);
        writeTileID    = id;
        tileOffsetX    = ox;
        tileOffsetY    = oy;
        startWriteback = 1'b1;
        n = 0;
        while (1) begin
            @(negedge BOARD_CLK);
            n++;
            if (n == 1) startWriteback = 1'b0;
            if (n == restart_at) begin
                startWriteback = 1'b1;
                writeTileID    = ~id;
            end
            if (n == restart_at + 1) startWriteback = 1'b0;
            if (n == reset_at) begin
                RESET = 1'b1;
                #1;
                check({tag, "_rst_we_n"}, {31'd0, SRAM_WE_N}, 32'd1);
                check({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                check({tag, "_rst_pix"}, {25'd0, pixelsWritten}, 32'd0);
                check({tag, "_rst_done"}, {31'd0, doneWriteback}, 32'd0);
                sb.delete();
                repeat (2) @(negedge BOARD_CLK);
                RESET = 1'b0;
                repeat (10) @(negedge BOARD_CLK);
                check({tag, "_no_done_pulse"}, done_cnt - d0, 32'd0);
                return;
            end
            if (doneWriteback === 1'b1) break;
            if (n >= 400) begin
                check({tag, "_done_timeout"}, 32'd1, 32'd0);
                break;
            end
        end
        check({tag, "_done_cycle"}, n, exp_done);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        check({tag, "_pixels"}, {25'd0, pixelsWritten}, exp_pix);
        repeat (20) @(negedge BOARD_CLK);
        check({tag, "_writes"}, wr_cnt, exp_wr);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
        check({tag, "_single_done"}, done_cnt - d0, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                tile0[x][y] = 16'(x + 8 * y);
                tile1[x][y] = 16'hBEEF;
            end

        repeat (3) @(negedge BOARD_CLK);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, doneWriteback}, 32'd0);
        check("reset_pix", {25'd0, pixelsWritten}, 32'd0);
        check("reset_addr", {12'd0, SRAM_ADDR}, 32'd0);
        check("reset_dq", {16'd0, SRAM_DQ}, 32'd0);
        check("reset_dq_en", {31'd0, SRAM_DQ_EN}, 32'd0);
        check("reset_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("reset_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        RESET = 1'b0;
        repeat (2) @(negedge BOARD_CLK);

        // Full on-screen tile from tile0 at the origin
        push_tile(1'b0, 0, 0, 8, 8);
        run_tile("full", 1'b0, 10'd0, 10'd0, 129, 64, 64, -1, -1);
        check("full_first_addr", {12'd0, first_addr}, 32'd0);
        check("full_last_addr", {12'd0, last_addr}, 32'd4487);

        // Tile 1 at (16,8); tile0 cleared so a wrong select shows as data 0
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) tile0[x][y] = 16'h0000;
        push_tile(1'b1, 16, 8, 8, 8);
        run_tile("sel", 1'b1, 10'd16, 10'd8, 129, 64, 64, -1, -1);
        check("sel_first_addr", {12'd0, first_addr}, 32'd5136);
        check("sel_last_addr", {12'd0, last_addr}, 32'd9623);

        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) tile0[x][y] = 16'(x + 8 * y);

        // Bottom-right corner: only a 4x4 region is visible
        push_tile(1'b0, 636, 476, 4, 4);
        run_tile("clip", 1'b0, 10'd636, 10'd476, 81, 16, 16, -1, -1);
        check("clip_first_addr", {12'd0, first_addr}, 32'd305276);
        check("clip_last_addr", {12'd0, last_addr}, 32'd307199);

        // Entirely off-screen: nothing written
        run_tile("offscreen", 1'b0, 10'd700, 10'd0, 65, 0, 0, -1, -1);

        // A second start mid-tile with the other tile selected must be ignored
        push_tile(1'b0, 0, 0, 8, 8);
        run_tile("restart", 1'b0, 10'd0, 10'd0, 129, 64, 64, 30, -1);

        // Reset mid-tile abandons the tile; a fresh start then completes
        push_tile(1'b0, 0, 0, 8, 8);
        run_tile("midreset", 1'b0, 10'd0, 10'd0, 0, 0, 0, -1, 40);
        push_tile(1'b0, 636, 476, 4, 4);
        run_tile("after_reset", 1'b0, 10'd636, 10'd476, 81, 16, 16, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
